// File: rtl/designs_selftest_pkg.sv
// Shared constants for the design self-test sequencer: FSM encoding,
// default parameters and a select-index width helper.
package designs_selftest_pkg;

  localparam int unsigned DEF_N_DESIGNS = 4;
  localparam int unsigned DEF_TIMEOUT   = 1000;
  localparam int unsigned DEF_TIMEOUT_W = 16;
  localparam int unsigned DEF_CONT_MODE = 0;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_LAUNCH = 2'd1;
  localparam logic [STATE_W-1:0] ST_WAIT   = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE   = 2'd3;

  // Index width that stays legal for a single design.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/designs_selftest_seq_if.sv
// Select/start/done/pass bundle between the sequencer and the designs under test.
interface designs_selftest_seq_if
  import designs_selftest_pkg::*;
#(
  parameter int unsigned N_DESIGNS = DEF_N_DESIGNS
);
  logic [N_DESIGNS-1:0] o_sel;
  logic                 o_start;
  logic [N_DESIGNS-1:0] i_done;
  logic [N_DESIGNS-1:0] i_pass;

  modport master (output o_sel, output o_start, input i_done, input i_pass);
  modport slave  (input o_sel, input o_start, output i_done, output i_pass);
endinterface

// File: rtl/designs_selftest_seq_timer.sv
// Per-design timeout counter; expired_o is high while the count sits at TIMEOUT-1.
module selftest_timer
  import designs_selftest_pkg::*;
#(
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned TIMEOUT_W = DEF_TIMEOUT_W
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 expired_q, expired_d;

  // Saturate at the last count so expiry stays asserted.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
    expired_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/designs_selftest_seq.sv
// Sequencer that starts each design in turn, collects pass/fail with a
// per-design timeout and reports a completion-flagged result vector.
module designs_selftest_seq
  import designs_selftest_pkg::*;
#(
  parameter int unsigned N_DESIGNS = DEF_N_DESIGNS,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned TIMEOUT_W = DEF_TIMEOUT_W,
  parameter int unsigned CONT_MODE = DEF_CONT_MODE
) (
  input  logic                  i_clock,
  input  logic                  i_rst_n,
  input  logic                  i_test,
  output logic                  o_busy,
  output logic [N_DESIGNS:0]    o_result,
  designs_selftest_seq_if.master bus
);

  localparam int unsigned          IDX_W    = idx_width(N_DESIGNS);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_DESIGNS - 1);

  logic                 test_q, test_prev_q, test_rise;
  logic [STATE_W-1:0]   state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_DESIGNS:0]   result_q, result_d;
  logic [N_DESIGNS-1:0] sel_q, sel_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 tmr_load, tmr_en, tmr_expired;
  logic                 cur_done;

  assign test_rise = test_q & ~test_prev_q;

  selftest_timer #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timer (
    .clk_i     (i_clock),
    .rst_ni    (i_rst_n),
    .load_i    (tmr_load),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    cur_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (test_rise) begin
          result_d = '0;
          idx_d    = '0;
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tmr_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        tmr_en   = 1'b1;
        cur_done = bus.i_done[idx_q];
        // A done seen on the expiry cycle still counts as a real result.
        if (cur_done || tmr_expired) begin
          result_d[idx_q] = cur_done & bus.i_pass[idx_q];
          if (idx_q == LAST_IDX) begin
            result_d[N_DESIGNS] = 1'b1;
            state_d             = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_DONE: begin
        if (test_rise || ((CONT_MODE != 0) && test_q)) begin
          result_d = '0;
          idx_d    = '0;
          state_d  = ST_LAUNCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d  = (state_d == ST_LAUNCH) || (state_d == ST_WAIT);
    start_d = (state_d == ST_LAUNCH);
    sel_d   = busy_d ? (N_DESIGNS'(1) << idx_d) : '0;
  end

  always_ff @(posedge i_clock) begin
    if (!i_rst_n) begin
      test_q      <= 1'b0;
      test_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      result_q    <= '0;
      sel_q       <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      test_q      <= i_test;
      test_prev_q <= test_q;
      state_q     <= state_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      sel_q       <= sel_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.o_sel   = sel_q;
  assign bus.o_start = start_q;
  assign o_busy      = busy_q;
  assign o_result    = result_q;

endmodule
